eth_pkt_gen: RTL

ETH_PKT_GEN -- requirements
Module: eth_pkt_gen

---
 rtl/eth_pkt_gen.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/eth_pkt_gen.sv
// eth_pkt_gen: Ethernet test-frame generator driving an AXI-Stream MAC TX port.
// Bursts of fixed-length frames with selectable payload and inter-frame gap.
//
// Ports:
//   clk_mac, rst_n        clock, async active-low reset
//   start, stop           burst request / end burst after current frame
//   cfg_len/count/gap/mode  burst config, latched on accepted start
//   tx_axis_mac_*         8-bit AXI-Stream master (tdata/tvalid/tlast/tready)
//   busy, done            burst active / one-cycle end-of-burst pulse
//   pkt_sent_cnt          frames completed in current or last burst
module eth_pkt_gen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0000_0000_0000,
  parameter logic [15:0] ETHERTYPE = 16'hEBEB,
  parameter int          MAX_LEN   = 1514,
  parameter int          CNT_W     = 16,
  parameter int          GAP_W     = 16
) (
  input  logic             clk_mac,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [10:0]      cfg_len,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [1:0]       cfg_mode,
  output logic [7:0]       tx_axis_mac_tdata,
  output logic             tx_axis_mac_tvalid,
  output logic             tx_axis_mac_tlast,
  input  logic             tx_axis_mac_tready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkt_sent_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [10:0] LMIN = 11'd60;
  localparam logic [10:0] LMAX = 11'(MAX_LEN);
  localparam logic [7:0]  SEED = 8'hFF;
  localparam logic [7:0]  HDR0 = DST_MAC[47:40];

  state_t           r_state;
  logic [10:0]      r_len_m1;
  logic [CNT_W-1:0] r_count;
  logic [GAP_W-1:0] r_gap;
  logic [1:0]       r_mode;
  logic [10:0]      r_idx;
  logic [7:0]       r_seq;
  logic [7:0]       r_lfsr;
  logic             r_stop;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_tdata;
  logic             r_tvalid;
  logic             r_tlast;
  logic             r_busy;
  logic             r_done;

  logic [10:0]      w_len;
  logic [10:0]      w_nidx;
  logic [7:0]       w_lfsr_use;
  logic [7:0]       w_nbyte;
  logic             w_hs;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_end;

  function automatic logic [7:0] f_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] f_byte(
    input logic [10:0] idx,
    input logic [1:0]  mode,
    input logic [7:0]  seq,
    input logic [7:0]  lfsr
  );
    logic [7:0] b;
    b = '0;
    unique case (1'b1)
      (idx < 11'd6):
        b = 8'(DST_MAC >> (6'd40 - {idx[2:0], 3'b000}));
      (idx >= 11'd6 && idx < 11'd12):
        b = 8'(SRC_MAC >> (7'd88 - {idx[3:0], 3'b000}));
      (idx == 11'd12 || idx == 11'd13):
        b = idx[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];
      (idx >= 11'd14): begin
        unique case (mode)
          2'd0: b = idx[7:0];
          2'd1: b = seq;
          2'd2: b = lfsr;
          2'd3: b = 8'h00;
        endcase
      end
    endcase
    return b;
  endfunction

  always_comb begin
    w_len = cfg_len;
    if (cfg_len < LMIN) w_len = LMIN;
    else if (cfg_len > LMAX) w_len = LMAX;
  end

  // LFSR only advances once a payload byte has been handed over
  assign w_nidx     = r_idx + 11'd1;
  assign w_lfsr_use = (r_idx >= 11'd14) ? f_step(r_lfsr) : r_lfsr;
  assign w_nbyte    = f_byte(w_nidx, r_mode, r_seq, w_lfsr_use);
  assign w_hs       = r_tvalid & tx_axis_mac_tready;
  assign w_cnt_nx   = r_cnt + 1'b1;
  assign w_end      = r_stop | stop |
                      ((r_count != '0) && (w_cnt_nx == r_count));

  always_ff @(posedge clk_mac or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_len_m1  <= '0;
      r_count   <= '0;
      r_gap     <= '0;
      r_mode    <= '0;
      r_idx     <= '0;
      r_seq     <= '0;
      r_lfsr    <= '0;
      r_stop    <= 1'b0;
      r_gap_cnt <= '0;
      r_cnt     <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_len_m1 <= w_len - 11'd1;
            r_count  <= cfg_count;
            r_gap    <= cfg_gap;
            r_mode   <= cfg_mode;
            r_cnt    <= '0;
            r_seq    <= '0;
            r_stop   <= 1'b0;
            r_idx    <= '0;
            r_lfsr   <= SEED;
            r_tdata  <= HDR0;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (stop) r_stop <= 1'b1;
          if (w_hs) begin
            if (r_idx != r_len_m1) begin
              r_idx   <= w_nidx;
              r_tdata <= w_nbyte;
              r_tlast <= (w_nidx == r_len_m1);
              r_lfsr  <= w_lfsr_use;
            end else begin
              r_cnt   <= w_cnt_nx;
              r_seq   <= r_seq + 8'd1;
              r_idx   <= '0;
              r_lfsr  <= SEED;
              r_tlast <= 1'b0;
              if (w_end) begin
                r_state  <= S_IDLE;
                r_tvalid <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_stop   <= 1'b0;
              end else if (r_gap == '0) begin
                r_tdata <= HDR0;
              end else begin
                r_state   <= S_GAP;
                r_tvalid  <= 1'b0;
                r_gap_cnt <= r_gap;
              end
            end
          end
        end
        S_GAP: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_stop  <= 1'b0;
          end else if (r_gap_cnt == GAP_W'(1)) begin
            r_state  <= S_SEND;
            r_tvalid <= 1'b1;
            r_tdata  <= HDR0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_axis_mac_tdata  = r_tdata;
  assign tx_axis_mac_tvalid = r_tvalid;
  assign tx_axis_mac_tlast  = r_tlast;
  assign busy               = r_busy;
  assign done               = r_done;
  assign pkt_sent_cnt       = r_cnt;

endmodule
